// File: rtl/serializer_pkg.sv
// Shared constants for the serializer: default bank geometry and FSM encoding.
package serializer_pkg;

  // Default encrypter bank geometry
  localparam int SER_NUM_ENCRYPTERS  = 4;
  localparam int SER_ENCRYPTER_WIDTH = 32;

  // Width of the nibble counter for the default packet width
  localparam int SER_NIBBLE_COUNT_REG = $clog2(SER_ENCRYPTER_WIDTH / 4);

  // FSM encoding; 2'd2 and 2'd3 are illegal and recover to IDLE
  typedef enum logic [1:0] {
    SER_STATE_IDLE  = 2'd0,
    SER_STATE_SHIFT = 2'd1
  } ser_state_t;

endpackage

// File: rtl/serializer_shift_reg.sv
// W-bit packet register: parallel load or shift left by one nibble.
// Load wins over shift so a back-to-back packet replaces the old one cleanly.
module serializer_shift_reg
  import serializer_pkg::*;
#(
  parameter int W = SER_ENCRYPTER_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [3:0]   msb_nibble
);

  logic [W-1:0] shift_reg;

  // Load a new packet, or move the next nibble into the MSB position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= din;
    end else if (shift) begin
      shift_reg <= {shift_reg[W-5:0], 4'h0};
    end
  end

  assign msb_nibble = shift_reg[W-1:W-4];

endmodule

// File: rtl/serializer.sv
// Collects packets from the encrypter bank in strict round-robin order and
// streams each one out as QSPI nibbles, MSB nibble first.
//
// Handshakes:
//  - Encrypter side: valid[i] high means packet i is ready; ack[i] pulses for
//    one cycle after the edge that captured it, and the encrypter drops valid
//    at the edge where it sees ack.
//  - QSPI side: a nibble moves on every rising edge where qspi_sending and
//    qspi_ready are both high; with ready low the nibble is held unchanged.
module serializer
  import serializer_pkg::*;
#(
  parameter int NUM_ENCRYPTERS  = SER_NUM_ENCRYPTERS,
  parameter int ENCRYPTER_WIDTH = SER_ENCRYPTER_WIDTH,
  localparam int NIBBLES = ENCRYPTER_WIDTH / 4,
  localparam int IDX_W   = $clog2(NUM_ENCRYPTERS),
  localparam int NIB_W   = $clog2(NIBBLES)
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             prog,
  input  logic [NUM_ENCRYPTERS-1:0][ENCRYPTER_WIDTH-1:0]   encrypters_result,
  input  logic [NUM_ENCRYPTERS-1:0]                        encrypters_result_valid,
  output logic [NUM_ENCRYPTERS-1:0]                        encrypters_result_ack,
  output logic [3:0]                                       qspi_data,
  output logic                                             qspi_sending,
  input  logic                                             qspi_ready,
  output logic [1:0]                                       state_out,
  output logic [IDX_W-1:0]                                 encrypter_index_out,
  output logic [NIB_W-1:0]                                 nibble_index_out
);

  ser_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] load_idx;
  logic [NIB_W-1:0] nib;
  logic             xfer;
  logic             last_nib;
  logic             load;
  logic [3:0]       head_nibble;

  assign next_idx = (idx == IDX_W'(NUM_ENCRYPTERS - 1)) ? '0 : idx + IDX_W'(1);
  assign xfer     = (state == SER_STATE_SHIFT) && qspi_ready;
  assign last_nib = (nib == NIB_W'(NIBBLES - 1));

  // In SHIFT the only possible capture is the back-to-back one at the next index
  assign load_idx = (state == SER_STATE_SHIFT) ? next_idx : idx;
  assign load     = ((state == SER_STATE_IDLE) && encrypters_result_valid[idx]) ||
                    (xfer && last_nib && encrypters_result_valid[next_idx]);

  serializer_shift_reg #(
    .W (ENCRYPTER_WIDTH)
  ) u_shift_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .shift      (xfer),
    .din        (encrypters_result[load_idx]),
    .msb_nibble (head_nibble)
  );

  // Control FSM: round-robin index, nibble counter and ack pulse generation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= SER_STATE_IDLE;
      idx                   <= '0;
      nib                   <= '0;
      encrypters_result_ack <= '0;
    end else begin
      encrypters_result_ack <= '0;
      case (state)
        SER_STATE_IDLE: begin
          if (encrypters_result_valid[idx]) begin
            nib                        <= '0;
            encrypters_result_ack[idx] <= 1'b1;
            state                      <= SER_STATE_SHIFT;
          end else if (prog) begin
            idx <= '0;
          end
        end
        SER_STATE_SHIFT: begin
          if (qspi_ready) begin
            if (last_nib) begin
              idx <= next_idx;
              nib <= '0;
              if (encrypters_result_valid[next_idx]) begin
                encrypters_result_ack[next_idx] <= 1'b1;
              end else begin
                state <= SER_STATE_IDLE;
              end
            end else begin
              nib <= nib + NIB_W'(1);
            end
          end
        end
        default: begin
          state <= SER_STATE_IDLE;
        end
      endcase
    end
  end

  assign qspi_sending        = (state == SER_STATE_SHIFT);
  assign qspi_data           = (state == SER_STATE_SHIFT) ? head_nibble : 4'h0;
  assign state_out           = state;
  assign encrypter_index_out = idx;
  assign nibble_index_out    = nib;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for the serializer with N=4 encrypters of 32-bit packets.
module tb_serializer;

  localparam int N = 4;
  localparam int W = 32;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                  prog = 1'b0;
  logic [N-1:0][W-1:0]   enc_result = '0;
  logic [N-1:0]          enc_valid = '0;
  logic [N-1:0]          enc_ack;
  logic [3:0]            qspi_data;
  logic                  qspi_sending;
  logic                  qspi_ready = 1'b1;
  logic [1:0]            state_out;
  logic [1:0]            encrypter_index_out;
  logic [2:0]            nibble_index_out;

  serializer #(
    .NUM_ENCRYPTERS  (N),
    .ENCRYPTER_WIDTH (W)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .prog                    (prog),
    .encrypters_result       (enc_result),
    .encrypters_result_valid (enc_valid),
    .encrypters_result_ack   (enc_ack),
    .qspi_data               (qspi_data),
    .qspi_sending            (qspi_sending),
    .qspi_ready              (qspi_ready),
    .state_out               (state_out),
    .encrypter_index_out     (encrypter_index_out),
    .nibble_index_out        (nibble_index_out)
  );

  // Scoreboard
  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          send_cycles;
  int          bubbles;
  int          xfers;
  logic [31:0] ack_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 2ns after the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_packet(input logic [W-1:0] pkt);
    for (int k = W/4 - 1; k >= 0; k--) exp_q.push_back(pkt[4*k +: 4]);
  endtask

  task automatic check_idle(input string tag, input logic [1:0] exp_idx);
    check({tag, "_sending"}, {31'd0, qspi_sending}, 32'd0);
    check({tag, "_data"}, {28'd0, qspi_data}, 32'd0);
    check({tag, "_ack"}, {28'd0, enc_ack}, 32'd0);
    check({tag, "_state"}, {30'd0, state_out}, 32'd0);
    check({tag, "_idx"}, {30'd0, encrypter_index_out}, {30'd0, exp_idx});
  endtask

  // Driver + monitor: acts as the encrypters (drop valid on ack) and as the
  // QSPI sink (optional stall window), checking every transferred nibble
  task automatic stream(input int stall_at, input int stall_len, input int stop_after);
    int  stall_ctr = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    send_cycles = 0;
    bubbles     = 0;
    xfers       = 0;
    ack_code    = '0;
    qspi_ready  = 1'b1;
    while ((exp_q.size() != 0 || qspi_sending) && cyc < 200 && xfers != stop_after) begin
      step();
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (enc_ack[i]) begin
          ack_code     = {ack_code[27:0], 4'(i + 1)};
          enc_valid[i] = 1'b0;
        end
      end
      if (qspi_sending) begin
        started = 1'b1;
        send_cycles++;
        if (exp_q.size() == 0) begin
          check("extra_nibble", {28'd0, qspi_data}, 32'hFFFF_FFFF);
          qspi_ready = 1'b1;
        end else if (xfers == stall_at && stall_ctr < stall_len) begin
          qspi_ready = 1'b0;
          stall_ctr++;
          check("stall_hold", {28'd0, qspi_data}, {28'd0, exp_q[0]});
          check("stall_nib", {29'd0, nibble_index_out}, 32'(stall_at));
        end else begin
          qspi_ready = 1'b1;
          check("nibble", {28'd0, qspi_data}, {28'd0, exp_q.pop_front()});
          xfers++;
        end
      end else if (started && exp_q.size() != 0) begin
        bubbles++;
      end
    end
    check("stream_in_budget", {31'd0, cyc < 200}, 32'd1);
    qspi_ready = 1'b1;
  endtask

  initial begin
    // 1. Reset and quiet bus
    repeat (3) @(posedge clk);
    #2;
    check_idle("in_reset", 2'd0);
    check("in_reset_nib", {29'd0, nibble_index_out}, 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check_idle("quiet", 2'd0);
    end

    // 2. Single packet from encrypter 0
    enc_result[0] = 32'hDEADBEEF;
    enc_valid[0]  = 1'b1;
    push_packet(32'hDEADBEEF);
    stream(-1, 0, -1);
    check("t2_ack", ack_code, 32'h1);
    check("t2_cycles", send_cycles, 32'd8);
    check_idle("t2_after", 2'd1);

    // 3. Out-of-turn valid is ignored, then back-to-back 1 -> 2
    enc_result[2] = 32'h89ABCDEF;
    enc_valid[2]  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_idle("t3_skip", 2'd1);
    end
    enc_result[1] = 32'h01234567;
    enc_valid[1]  = 1'b1;
    push_packet(32'h01234567);
    push_packet(32'h89ABCDEF);
    stream(-1, 0, -1);
    check("t3_ack", ack_code, 32'h23);
    check("t3_bubbles", bubbles, 32'd0);
    check("t3_cycles", send_cycles, 32'd16);
    check_idle("t3_after", 2'd3);

    // 4. Sink stalls 3 cycles after the 2nd nibble
    enc_result[3] = 32'h13579BDF;
    enc_valid[3]  = 1'b1;
    push_packet(32'h13579BDF);
    stream(2, 3, -1);
    check("t4_ack", ack_code, 32'h4);
    check("t4_cycles", send_cycles, 32'd11);
    check_idle("t4_after", 2'd0);

    // 5. Four packets in order, then wrap to 0, then prog re-sync
    for (int i = 0; i < N; i++) begin
      enc_result[i] = 32'hA0B0C0D0 + 32'(i * 32'h01010101);
      enc_valid[i]  = 1'b1;
      push_packet(32'hA0B0C0D0 + 32'(i * 32'h01010101));
    end
    stream(-1, 0, -1);
    check("t5_ack", ack_code, 32'h1234);
    check("t5_bubbles", bubbles, 32'd0);
    check("t5_cycles", send_cycles, 32'd32);
    enc_result[0] = 32'h55AA33CC;
    enc_valid[0]  = 1'b1;
    push_packet(32'h55AA33CC);
    stream(-1, 0, -1);
    check("t5_wrap_ack", ack_code, 32'h1);
    // prog held high across a whole packet must not move the index
    enc_result[1] = 32'h76543210;
    enc_valid[1]  = 1'b1;
    prog          = 1'b1;
    push_packet(32'h76543210);
    stream(-1, 0, -1);
    check("t5_prog_in_shift_ack", ack_code, 32'h2);
    check_idle("t5_idx2", 2'd2);
    step();
    prog = 1'b0;
    check_idle("t5_prog", 2'd0);

    // 6. Reset after the 3rd nibble
    enc_result[0] = 32'hCAFEF00D;
    enc_valid[0]  = 1'b1;
    push_packet(32'hCAFEF00D);
    stream(-1, 0, 3);
    step();
    reset = 1'b0;
    #1;
    check_idle("t6_reset", 2'd0);
    check("t6_reset_nib", {29'd0, nibble_index_out}, 32'd0);
    exp_q.delete();
    step();
    check_idle("t6_held", 2'd0);
    reset = 1'b1;
    step();
    check_idle("t6_released", 2'd0);
    enc_result[0] = 32'h0F1E2D3C;
    enc_result[1] = 32'h4B5A6978;
    enc_valid[0]  = 1'b1;
    enc_valid[1]  = 1'b1;
    push_packet(32'h0F1E2D3C);
    push_packet(32'h4B5A6978);
    stream(-1, 0, -1);
    check("t6_ack", ack_code, 32'h12);
    check("t6_bubbles", bubbles, 32'd0);
    check_idle("t6_after", 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
